// File: rtl/seg_pkg.sv
// Shared types and the active-low hex decode table for the seven-segment scan controller.
// Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg_pkg;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam seg_t       SEG_OFF    = 7'h7F;
  localparam logic [3:0] ANODES_OFF = 4'hF;

  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble to active-low segment decode (0-F).
// Zero latency; no flow control.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_display_ctrl.sv
// 4-digit multiplexed seven-segment scanner; updates commit only at frame boundaries.
// All outputs registered; optional leading-zero blanking via SEG_LEADING_ZERO_BLANK_EN.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int BLANK    = 2
) (
  input  logic        clk,
  input  logic        n_sync_reset,
  input  logic [15:0] value_i,
  input  logic        load_i,
  output logic        pending_o,
  output seg_t        seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        frame_o
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  digit_idx_t    idx_q, idx_d;
  logic          active_q;
  logic [15:0]   pend_q, disp_q, disp_d;
  logic          pending_d, commit, frame_d;
  logic [3:0]    nib, an_d;
  seg_t          dec_seg, seg_d;

  seg_decoder u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // Outputs are registered from next-state values so they line up with presc_q/idx_q.
  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    commit    = active_q && (presc_q == PRESC_LAST) && (idx_q == 2'd3);
    disp_d    = disp_q;
    pending_d = pending_o;
    nib       = 4'h0;
    an_d      = ANODES_OFF;
    seg_d     = SEG_OFF;
    frame_d   = 1'b0;

    if (!active_q) begin
      presc_d = '0;
      idx_d   = 2'd0;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (commit && pending_o) disp_d = pend_q;
    if (load_i)       pending_d = 1'b1;
    else if (commit)  pending_d = 1'b0;

    case (idx_d)
      2'd0:    nib = disp_d[3:0];
      2'd1:    nib = disp_d[7:4];
      2'd2:    nib = disp_d[11:8];
      default: nib = disp_d[15:12];
    endcase

    if (presc_d >= PW'(BLANK)) an_d = ~(4'b0001 << idx_d);

`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (((idx_d == 2'd1) && (disp_d[15:4]  == 12'h0)) ||
        ((idx_d == 2'd2) && (disp_d[15:8]  == 8'h0))  ||
        ((idx_d == 2'd3) && (disp_d[15:12] == 4'h0)))
      seg_d = SEG_OFF;
    else
      seg_d = dec_seg;
`else
    seg_d = dec_seg;
`endif

    frame_d = (presc_d == '0) && (idx_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!n_sync_reset) begin
      presc_q   <= '0;
      idx_q     <= 2'd0;
      active_q  <= 1'b0;
      pend_q    <= 16'h0;
      disp_q    <= 16'h0;
      pending_o <= 1'b0;
      an_o      <= ANODES_OFF;
      seg_o     <= SEG_OFF;
      dp_o      <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      active_q  <= 1'b1;
      if (load_i) pend_q <= value_i;
      disp_q    <= disp_d;
      pending_o <= pending_d;
      an_o      <= an_d;
      seg_o     <= seg_d;
      dp_o      <= 1'b1;
      frame_o   <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl at PRESCALE=8, BLANK=2 with a queue of expected frames.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        n_sync_reset;
  logic [15:0] value_i;
  logic        load_i;
  logic        pending_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int passed = 0;
  int total  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  seg_display_ctrl #(.PRESCALE(8), .BLANK(2)) dut (
    .clk          (clk),
    .n_sync_reset (n_sync_reset),
    .value_i      (value_i),
    .load_i       (load_i),
    .pending_o    (pending_o),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_o      (frame_o)
  );

  function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
    logic [3:0] n;
    n = v[d*4 +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if (d > 0 && (v >> (4*d)) == 16'h0) return 7'h7F;
`endif
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (frame_o !== 1'b1 && n < 100);
    check("frame_timeout", 32'(n < 100), 32'd1);
  endtask

  // Starts on a frame's first cycle, checks all 32 scan cycles, ends on the next frame start.
  task automatic check_frame(input logic [15:0] v, input string tag);
    logic [3:0] a;
    for (int k = 0; k < 32; k++) begin
      a = 4'b0001 << (k / 8);
      a = ((k % 8) < 2) ? 4'hF : ~a;
      check({tag, "_an"},    32'(an_o),    32'(a));
      check({tag, "_seg"},   32'(seg_o),   32'(exp_seg(v, k / 8)));
      check({tag, "_frame"}, 32'(frame_o), 32'(k == 0));
      check({tag, "_dp"},    32'(dp_o),    32'd1);
      tick();
    end
  endtask

  task automatic load(input logic [15:0] v);
    value_i = v;
    load_i  = 1'b1;
    tick();
    load_i  = 1'b0;
  endtask

  initial begin
    int n;
    n_sync_reset = 1'b0;
    value_i      = 16'h0;
    load_i       = 1'b0;

    // Reset and scan timing
    ticks(5);
    check("rst_an", 32'(an_o), 32'hF);
    check("rst_seg", 32'(seg_o), 32'h7F);
    check("rst_pend", 32'(pending_o), 32'd0);
    check("rst_frame", 32'(frame_o), 32'd0);
    check("rst_dp", 32'(dp_o), 32'd1);
    n_sync_reset = 1'b1;
    tick();
    check("rel_frame", 32'(frame_o), 32'd1);
    check("rel_an0", 32'(an_o), 32'hF);
    tick();
    check("rel_frame2", 32'(frame_o), 32'd0);
    check("rel_an1", 32'(an_o), 32'hF);
    tick();
    check("rel_an2", 32'(an_o), 32'hE);
    wait_frame(n);
    check("period", 32'(n + 2), 32'd32);
    exp_q.push_back(16'h0000);
    check_frame(exp_q.pop_front(), "init");

    // Mid-frame load commits at next boundary
    ticks(10);
    load(16'h12AF);
    exp_q.push_back(16'h12AF);
    check("load_pend", 32'(pending_o), 32'd1);
    wait_frame(n);
    check("commit_pend", 32'(pending_o), 32'd0);
    check("d0_F", 32'(seg_o), 32'h0E);
    check_frame(exp_q.pop_front(), "v12AF");

    // Last load before commit wins
    ticks(5);
    load(16'h1111);
    ticks(3);
    load(16'h2222);
    exp_q.push_back(16'h2222);
    wait_frame(n);
    check_frame(exp_q.pop_front(), "v2222");

    // Load on the commit edge while another value is pending
    ticks(3);
    load(16'h4444);
    exp_q.push_back(16'h4444);
    ticks(27);
    load(16'h3333);
    exp_q.push_back(16'h3333);
    check("edge_frame", 32'(frame_o), 32'd1);
    check("edge_pend", 32'(pending_o), 32'd1);
    check_frame(exp_q.pop_front(), "v4444");
    check("edge_pend2", 32'(pending_o), 32'd0);
    check_frame(exp_q.pop_front(), "v3333");

    // One-cycle reset mid digit-2 dwell with a pending value
    ticks(2);
    load(16'h5555);
    ticks(17);
    check("mid_an", 32'(an_o), 32'hB);
    n_sync_reset = 1'b0;
    tick();
    check("mr_an", 32'(an_o), 32'hF);
    check("mr_seg", 32'(seg_o), 32'h7F);
    check("mr_pend", 32'(pending_o), 32'd0);
    check("mr_frame", 32'(frame_o), 32'd0);
    n_sync_reset = 1'b1;
    exp_q.push_back(16'h0000);
    tick();
    check_frame(exp_q.pop_front(), "mr_v0");
    check("mr_pend2", 32'(pending_o), 32'd0);
    check_frame(16'h0000, "mr_v0b");

    // Leading-zero pattern
    ticks(4);
    load(16'h00A0);
    exp_q.push_back(16'h00A0);
    wait_frame(n);
    check_frame(exp_q.pop_front(), "v00A0");
    check("end_pend", 32'(pending_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
